hilo_mdu: RTL and testbench

- Multiply/divide unit with HI/LO registers, sitting in the E stage of the five-stage MIPS pipeline.
- Executes mult/multu/div/divu over a multi-cycle latency, and executes mthi/mtlo in one cycle.
- Drives hilo_busy to the stall unit, which stalls any D-stage md/mt/mf instruction while hilo_busy is high.
- Honours the exception/interrupt request so that an E-stage instruction being flushed never modifies HI/LO.

---
 rtl/hilo_mdu.sv | 173 +++++++++++++++++
 tb/tb_hilo_mdu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit for the E stage. Operations are accepted when idle,
// and multi-cycle mult/div results are committed to HI/LO after a fixed busy window.
module hilo_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic        hilo_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        r_hi;
  logic [31:0]        w_hi_nxt;
  logic [31:0]        r_lo;
  logic [31:0]        w_lo_nxt;
  logic [63:0]        r_pend;
  logic [63:0]        w_pend_nxt;
  logic               r_pend_we;
  logic               w_pend_we_nxt;

  logic               w_accept;
  logic               w_md_start;
  logic [63:0]        w_a_sx;
  logic [63:0]        w_b_sx;
  logic [63:0]        w_smul;
  logic [63:0]        w_umul;
  logic [63:0]        w_sdiv;
  logic [63:0]        w_udiv;

  // Sign-magnitude division returning {remainder, quotient}; a zero divisor is
  // replaced by 1 so the datapath stays defined (the result is discarded anyway).
  // The -2^31 / -1 case falls out naturally: magnitude 2^31 negates to itself.
  function automatic logic [63:0] div32(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q;
    logic [31:0] r;
    a_mag = (sgn && a[31]) ? (32'd0 - a) : a;
    b_mag = (sgn && b[31]) ? (32'd0 - b) : b;
    b_mag = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q     = a_mag / b_mag;
    r     = a_mag % b_mag;
    q     = (sgn && (a[31] ^ b[31])) ? (32'd0 - q) : q;
    r     = (sgn && a[31]) ? (32'd0 - r) : r;
    return {r, q};
  endfunction

  assign w_accept   = start && !req && (r_state == S_IDLE) &&
                      (md_op >= OP_MULT) && (md_op <= OP_MTLO);
  assign w_md_start = w_accept && (md_op <= OP_DIVU);

  assign w_a_sx = {{32{A[31]}}, A};
  assign w_b_sx = {{32{B[31]}}, B};
  assign w_smul = w_a_sx * w_b_sx;
  assign w_umul = {32'd0, A} * {32'd0, B};
  assign w_sdiv = div32(A, B, 1'b1);
  assign w_udiv = div32(A, B, 1'b0);

  assign busy      = (r_state == S_RUN);
  assign hilo_busy = busy || w_md_start;
  assign hi        = r_hi;
  assign lo        = r_lo;

  // Next-state, countdown and HI/LO update logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_nxt    = r_pend;
    w_pend_we_nxt = r_pend_we;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (md_op)
            OP_MULT: begin
              w_pend_nxt    = w_smul;
              w_pend_we_nxt = 1'b1;
              w_cnt_nxt     = CNT_W'(MULT_CYCLES);
              w_state_nxt   = S_RUN;
            end
            OP_MULTU: begin
              w_pend_nxt    = w_umul;
              w_pend_we_nxt = 1'b1;
              w_cnt_nxt     = CNT_W'(MULT_CYCLES);
              w_state_nxt   = S_RUN;
            end
            OP_DIV: begin
              w_pend_nxt    = w_sdiv;
              w_pend_we_nxt = (B != 32'd0);
              w_cnt_nxt     = CNT_W'(DIV_CYCLES);
              w_state_nxt   = S_RUN;
            end
            OP_DIVU: begin
              w_pend_nxt    = w_udiv;
              w_pend_we_nxt = (B != 32'd0);
              w_cnt_nxt     = CNT_W'(DIV_CYCLES);
              w_state_nxt   = S_RUN;
            end
            OP_MTHI: w_hi_nxt = A;
            OP_MTLO: w_lo_nxt = A;
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          if (r_pend_we) begin
            w_hi_nxt = r_pend[63:32];
            w_lo_nxt = r_pend[31:0];
          end else begin
            w_hi_nxt = r_hi;
          end
          w_cnt_nxt   = CNT_W'(0);
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= CNT_W'(0);
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend    <= 64'd0;
      r_pend_we <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_we <= w_pend_we_nxt;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: driver pushes expected HI/LO from an arithmetic
// reference model, monitor pops and compares when an operation completes.
module tb_hilo_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        req = 1'b0;
  logic        busy;
  logic        hilo_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .req(req), .busy(busy), .hilo_busy(hilo_busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
  exp_t scb[$];
  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural HI/LO effect of one accepted operation.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] up;
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb); {m_hi, m_lo} = sp; end
      3'd2: begin ua = {32'd0, a}; ub = {32'd0, b}; up = ua * ub; {m_hi, m_lo} = up; end
      3'd3: if (b != 32'd0) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          m_lo = 32'h80000000; m_hi = 32'd0;
        end else begin
          m_lo = sa / sb; m_hi = sa % sb;
        end
      end
      3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Monitor: completion is a busy fall, or the cycle after an accepted mthi/mtlo.
  logic rst_seen = 1'b1;
  logic prev_busy = 1'b0;
  logic pend_mt = 1'b0;
  exp_t got;
  always @(posedge clk) rst_seen = reset;
  always @(negedge clk) begin
    if (!rst_seen && (pend_mt || (prev_busy && !busy))) begin
      if (scb.size() == 0) begin
        chk("scb_underflow", 32'd1, 32'd0);
      end else begin
        got = scb.pop_front();
        chk("sb_hi", hi, got.hi);
        chk("sb_lo", lo, got.lo);
      end
    end
    pend_mt = start && !req && !busy && !reset && (md_op == 3'd5 || md_op == 3'd6);
    prev_busy = busy;
  end

  // Issue one op in the current cycle; optionally pulse req or reset mid-run.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rq, input int pulse_at, input int reset_at);
    bit acc;
    bit is_md;
    int n;
    int cnt;
    exp_t e;
    is_md = (op >= 3'd1 && op <= 3'd4);
    acc   = !rq && (op >= 3'd1 && op <= 3'd6);
    n     = (op <= 3'd2) ? MC : DC;
    start = 1'b1; md_op = op; A = a; B = b; req = rq;
    if (acc) begin
      model_apply(op, a, b);
      e.hi = m_hi; e.lo = m_lo;
      scb.push_back(e);
    end
    @(negedge clk);
    chk("hilo_busy_T", 32'(hilo_busy), 32'(acc && is_md));
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0; md_op = 3'd0;
    if (acc && is_md) begin
      cnt = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (!busy) break;
        cnt++;
        chk("hilo_busy_run", 32'(hilo_busy), 32'd1);
        req = (cnt == pulse_at);
        if (cnt == reset_at) begin
          reset = 1'b1;
          scb.delete();
          m_hi = 32'd0; m_lo = 32'd0;
        end
      end
      req = 1'b0;
      if (reset_at > 0) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        reset = 1'b0;
      end else begin
        chk("busy_cycles", 32'(cnt), 32'(n));
      end
      @(posedge clk); #1;
    end else if (!acc) begin
      @(negedge clk);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_hi", hi, m_hi);
      chk("drop_lo", lo, m_lo);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rq;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hilo_busy", 32'(hilo_busy), 32'd0);
    @(posedge clk); #1;

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 0, 0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);
    run_op(3'd4, 32'd7, 32'd0, 1'b0, 0, 0);
    chk("divz_hi", hi, 32'hFFFFFFFF);
    chk("divz_lo", lo, 32'hFFFFFFFD);
    run_op(3'd5, 32'h12345678, 32'd0, 1'b0, 0, 0);
    run_op(3'd6, 32'h9ABCDEF0, 32'd0, 1'b0, 0, 0);
    @(negedge clk);
    chk("mt_busy", 32'(busy), 32'd0);
    chk("mt_hi", hi, 32'h12345678);
    chk("mt_lo", lo, 32'h9ABCDEF0);
    @(posedge clk); #1;
    run_op(3'd1, 32'd5, 32'd6, 1'b1, 0, 0);
    run_op(3'd3, 32'd100, 32'd7, 1'b0, 3, 0);
    chk("reqrun_hi", hi, 32'd2);
    chk("reqrun_lo", lo, 32'd14);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_lo", lo, 32'h80000000);
    run_op(3'd3, 32'd1000, 32'd3, 1'b0, 0, 2);
    run_op(3'd1, 32'd7, 32'd9, 1'b0, 0, 0);
    chk("post_rst_lo", lo, 32'd63);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      rq = ($urandom_range(0, 7) == 0);
      run_op(op, ra, rb, rq, 0, 0);
    end

    repeat (2) @(negedge clk);
    chk("scb_empty", 32'(scb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
